// File: rtl/encoder_pkg.sv
// Shared definitions for the 4-to-2 handshaked encoder: FSM encoding and default widths.
package encoder_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam int ERR_CNT_W_DEF = 8;

endpackage

// File: rtl/enc4_core.sv
// Combinational 4-to-2 priority encoder with zero and multi-hot flags.
module enc4_core #(
    parameter int PRIO_HIGH = 1
) (
    input  logic [3:0] d,
    output logic [1:0] idx,
    output logic       zero,
    output logic       multi
);

    logic [3:0] scan_set;

    // Re-order the bits so that a single "last set bit wins" scan covers both priorities.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_scan
            if (PRIO_HIGH != 0) begin : g_hi
                assign scan_set[gi] = d[gi];
            end else begin : g_lo
                assign scan_set[gi] = d[3 - gi];
            end
        end
    endgenerate

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (scan_set[i]) begin
                idx = (PRIO_HIGH != 0) ? 2'(i) : 2'(3 - i);
            end
        end
        zero  = (d == 4'd0);
        multi = ((d & (d - 4'd1)) != 4'd0);
    end

endmodule

// File: rtl/encoder_4_2_hs.sv
// 4-to-2 encoder behind a one-deep valid/ready output register with a saturating error counter.
module encoder_4_2_hs
    import encoder_pkg::*;
#(
    parameter int PRIO_HIGH = 1,
    parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [3:0]           i_D,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [1:0]           o_Y,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_zero,
    output logic                 o_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    state_t               state_reg;
    logic [1:0]           y_reg;
    logic                 zero_reg;
    logic                 err_reg;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    logic [1:0] core_idx;
    logic       core_zero;
    logic       core_multi;
    logic       accept;

    enc4_core #(
        .PRIO_HIGH(PRIO_HIGH)
    ) u_core (
        .d    (i_D),
        .idx  (core_idx),
        .zero (core_zero),
        .multi(core_multi)
    );

    // Ready depends only on the held state and downstream ready, never on i_valid.
    assign o_ready = (state_reg == ST_EMPTY) || i_ready;
    assign accept  = i_valid && o_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_EMPTY;
            y_reg       <= 2'd0;
            zero_reg    <= 1'b0;
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            if (accept) begin
                state_reg <= ST_FULL;
                y_reg     <= core_idx;
                zero_reg  <= core_zero;
                err_reg   <= core_multi;
                // Counting on accept only means a held sample is counted exactly once.
                if (core_multi && (err_cnt_reg != {ERR_CNT_W{1'b1}})) begin
                    err_cnt_reg <= err_cnt_reg + 1'b1;
                end
            end else if (i_ready) begin
                state_reg <= ST_EMPTY;
            end
        end
    end

    assign o_valid   = (state_reg == ST_FULL);
    assign o_Y       = y_reg;
    assign o_zero    = zero_reg;
    assign o_err     = err_reg;
    assign o_err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_encoder_4_2_hs.sv
// Scoreboard bench: both priority variants driven in parallel and compared against a queue model.
module tb_encoder_4_2_hs;

    typedef struct {
        logic [1:0] y;
        logic       z;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d   = 4'd0;
    logic       vld = 1'b0;
    logic       rdy = 1'b0;

    logic       ready_hi, valid_hi, zero_hi, err_hi;
    logic       ready_lo, valid_lo, zero_lo, err_lo;
    logic [1:0] y_hi, y_lo;
    logic [7:0] cnt_hi, cnt_lo;

    int checks   = 0;
    int failures = 0;

    exp_t q_hi[$];
    exp_t q_lo[$];
    bit   full_m = 1'b0;
    int   cnt_m  = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    encoder_4_2_hs #(.PRIO_HIGH(1), .ERR_CNT_W(8)) u_dut_hi (
        .i_clk(clk), .i_rst(rst), .i_D(d), .i_valid(vld), .o_ready(ready_hi),
        .o_Y(y_hi), .o_valid(valid_hi), .i_ready(rdy), .o_zero(zero_hi),
        .o_err(err_hi), .o_err_cnt(cnt_hi)
    );

    encoder_4_2_hs #(.PRIO_HIGH(0), .ERR_CNT_W(8)) u_dut_lo (
        .i_clk(clk), .i_rst(rst), .i_D(d), .i_valid(vld), .o_ready(ready_lo),
        .o_Y(y_lo), .o_valid(valid_lo), .i_ready(rdy), .o_zero(zero_lo),
        .o_err(err_lo), .o_err_cnt(cnt_lo)
    );

    // Reference encode: pick the winning set bit by index ordering, count bits arithmetically.
    function automatic exp_t ref_enc(input logic [3:0] w, input bit prio_high);
        exp_t r;
        int   win;
        win = -1;
        for (int i = 0; i < 4; i++) begin
            if (w[i] && (win < 0 || (prio_high ? (i > win) : (i < win)))) win = i;
        end
        r.y = (win < 0) ? 2'd0 : 2'(win);
        r.z = ($countones(w) == 0);
        r.e = ($countones(w) > 1);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the handshake: push expected responses on every accept.
    always @(posedge clk) begin
        if (rst) begin
            q_hi.delete();
            q_lo.delete();
            full_m = 1'b0;
            cnt_m  = 0;
        end else if (vld && (!full_m || rdy)) begin
            q_hi.push_back(ref_enc(d, 1'b1));
            q_lo.push_back(ref_enc(d, 1'b0));
            if ($countones(d) > 1 && cnt_m < 255) cnt_m = cnt_m + 1;
            full_m = 1'b1;
        end else if (rdy) begin
            full_m = 1'b0;
        end
    end

    // Monitor: compare held outputs to the queue front, pop when the downstream takes it.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t eh, el;
            chk("valid_hi", int'(valid_hi), int'(full_m));
            chk("valid_lo", int'(valid_lo), int'(full_m));
            chk("ready_hi", int'(ready_hi), int'(!full_m || rdy));
            chk("ready_lo", int'(ready_lo), int'(!full_m || rdy));
            chk("cnt_hi", int'(cnt_hi), cnt_m);
            chk("cnt_lo", int'(cnt_lo), cnt_m);
            if (full_m) begin
                if (q_hi.size() == 0 || q_lo.size() == 0) begin
                    chk("queue_nonempty", 0, 1);
                end else begin
                    eh = q_hi[0];
                    el = q_lo[0];
                    chk("y_hi", int'(y_hi), int'(eh.y));
                    chk("zero_hi", int'(zero_hi), int'(eh.z));
                    chk("err_hi", int'(err_hi), int'(eh.e));
                    chk("y_lo", int'(y_lo), int'(el.y));
                    chk("zero_lo", int'(zero_lo), int'(el.z));
                    chk("err_lo", int'(err_lo), int'(el.e));
                    $display("txn held y_hi=%0d y_lo=%0d zero=%0d err=%0d cnt=%0d taken=%0d",
                             y_hi, y_lo, zero_hi, err_hi, cnt_hi, rdy);
                    if (rdy) begin
                        void'(q_hi.pop_front());
                        void'(q_lo.pop_front());
                    end
                end
            end
        end
    end

    task automatic drive(input logic [3:0] dd, input logic v, input logic r, input logic rs);
        @(posedge clk);
        #1;
        d   = dd;
        vld = v;
        rdy = r;
        rst = rs;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, int'(valid_hi), 0);
        chk({tag, "_y"}, int'(y_hi), 0);
        chk({tag, "_zero"}, int'(zero_hi), 0);
        chk({tag, "_err"}, int'(err_hi), 0);
        chk({tag, "_cnt"}, int'(cnt_hi), 0);
        chk({tag, "_ready"}, int'(ready_hi), 1);
    endtask

    initial begin
        logic [3:0] sweep [4];
        sweep[0] = 4'b0001; sweep[1] = 4'b0010; sweep[2] = 4'b0100; sweep[3] = 4'b1000;

        // Reset state
        drive(4'd0, 1'b0, 1'b0, 1'b1);
        drive(4'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk_idle("reset");
        mon_en = 1'b1;

        // Single one-hot sample
        drive(4'b0100, 1'b1, 1'b1, 1'b0);
        drive(4'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("first_y", int'(y_hi), 2);
        chk("first_valid", int'(valid_hi), 1);

        // Back-to-back sweep
        for (int i = 0; i < 4; i++) drive(sweep[i], 1'b1, 1'b1, 1'b0);
        drive(4'd0, 1'b0, 1'b1, 1'b0);

        // Backpressure hold
        drive(4'b1000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(4'b0001, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("hold_y", int'(y_hi), 3);
        chk("hold_ready", int'(ready_hi), 0);
        drive(4'b0001, 1'b1, 1'b1, 1'b0);
        drive(4'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("release_y", int'(y_hi), 0);

        // Multi-hot held: counted once
        drive(4'd0, 1'b0, 1'b0, 1'b1);
        drive(4'b1010, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive(4'b1111, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("multi_y_hi", int'(y_hi), 3);
        chk("multi_y_lo", int'(y_lo), 1);
        chk("multi_err", int'(err_hi), 1);
        chk("multi_cnt", int'(cnt_hi), 1);

        // Saturation then zero input
        drive(4'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) drive(4'b1111, 1'b1, 1'b1, 1'b0);
        drive(4'b0000, 1'b1, 1'b1, 1'b0);
        drive(4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("sat_cnt", int'(cnt_hi), 255);
        chk("zero_flag", int'(zero_hi), 1);
        chk("zero_y", int'(y_hi), 0);

        // Reset while full with a concurrent accept
        drive(4'b0010, 1'b1, 1'b1, 1'b0);
        drive(4'b1000, 1'b1, 1'b1, 1'b1);
        drive(4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_idle("rst_full");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0));
        end
        drive(4'd0, 1'b0, 1'b1, 1'b0);
        drive(4'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/encoder_4_2_hs.md
ENCODER_4_2_HS -- requirements
Module: encoder_4_2_hs

Interface
REQ-001 SHALL have parameter PRIO_HIGH, default 1, meaning the highest set index wins on multi-hot input (0: lowest set index wins).
REQ-002 SHALL have parameter ERR_CNT_W, default 8, meaning the width of the error counter.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_D  input  4  input word to encode, nominally one-hot.
REQ-006 SHALL have port i_valid  input  1  upstream asserts that i_D is valid.
REQ-007 SHALL have port o_ready  output  1  block can accept i_D this cycle.
REQ-008 SHALL have port o_Y  output  2  encoded index of the held sample.
REQ-009 SHALL have port o_valid  output  1  o_Y/o_zero/o_err hold a valid sample.
REQ-010 SHALL have port i_ready  input  1  downstream accepts the held sample this cycle.
REQ-011 SHALL have port o_zero  output  1  held sample had no bit set.
REQ-012 SHALL have port o_err  output  1  held sample had more than one bit set.
REQ-013 SHALL have port o_err_cnt  output  ERR_CNT_W  count of accepted multi-hot samples.

Function
REQ-014 SHALL implement a two-state FSM: EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-015 SHALL drive o_ready = (state==EMPTY) || i_ready, combinationally, with no combinational path from i_valid.
REQ-016 SHALL accept a sample when i_valid && o_ready; output fields reflect it on the next cycle (latency 1).
REQ-017 EMPTY -> FULL on accept; FULL -> FULL on accept with i_ready; FULL -> EMPTY on i_ready without accept; otherwise hold.
REQ-018 SHALL keep o_Y, o_zero, o_err stable while o_valid=1 and i_ready=0, regardless of i_D or i_valid.
REQ-019 SHALL encode one-hot i_D as: 0001->0, 0010->1, 0100->2, 1000->3, with o_zero=0, o_err=0.
REQ-020 SHALL encode multi-hot i_D per PRIO_HIGH (PRIO_HIGH=1: 1010->3; PRIO_HIGH=0: 1010->1) and set o_err=1.
REQ-021 SHALL encode i_D=0000 as o_Y=0, o_zero=1, o_err=0; the sample is still delivered with o_valid=1.
REQ-022 SHALL increment o_err_cnt by 1 in the cycle after each accepted multi-hot sample, saturating at 2^ERR_CNT_W-1 (no wrap).
REQ-023 SHALL not count the same sample more than once, however long it is held.
REQ-024 SHALL ignore i_D content when no accept occurs (no encode, no count).

Reset
REQ-025 SHALL, on i_clk edge with i_rst=1, force state EMPTY, o_valid=0, o_Y=0, o_zero=0, o_err=0, o_err_cnt=0.
REQ-026 SHALL let reset override any simultaneous accept or downstream transfer; a held sample is discarded.
REQ-027 SHALL drive o_ready=1 in the first cycle after reset is released.

Structure
REQ-028 SHALL place FSM state encoding (EMPTY, FULL) and the default ERR_CNT_W constant in a shared package encoder_pkg.
REQ-029 SHALL contain one combinational sub-module enc4_core (i_D -> index, zero, multi flags, PRIO_HIGH parameter); the handshake register and counter stay in the top.

Verification
REQ-030 Reset then i_D=0100, i_valid=1, i_ready=1 for one cycle -> next cycle o_valid=1, o_Y=2, o_err=0, o_zero=0; o_err_cnt=0.
REQ-031 Sweep i_D=0001,0010,0100,1000 back-to-back with i_ready=1 -> o_Y=0,1,2,3 on consecutive cycles, o_ready constantly 1.
REQ-032 Accept i_D=1000, then i_ready=0 for 3 cycles while i_D=0001, i_valid=1 -> o_Y stays 3, o_ready=0; after i_ready=1, o_Y=0 next cycle.
REQ-033 Accept i_D=1010 (PRIO_HIGH=1) and hold 5 cycles -> o_Y=3, o_err=1, o_err_cnt=1 (not 5); with PRIO_HIGH=0 -> o_Y=1.
REQ-034 Accept 300 consecutive i_D=1111 samples, ERR_CNT_W=8 -> o_err_cnt reaches 255 and stays 255; i_D=0000 -> o_zero=1, o_Y=0.
REQ-035 Assert i_rst while FULL with i_valid=1, i_ready=1 -> next cycle o_valid=0, all outputs 0, o_ready=1.
